// File: rtl/level_to_set_reset.sv
// -----------------------------------------------------------------------------
// level_to_set_reset
//
// Turns an asynchronous external level (trigger, interlock, PMT gate) into
// clean set/reset pulses, one per qualified edge. It also provides a filtered
// copy of the level and saturating rise/fall edge counters for host readout.
//
// Ports
//   clock        system clock
//   reset_n      asynchronous active-low reset
//   level_in     asynchronous external level (sampled only by the synchronizer)
//   enable       1 = encoder active, 0 = filter and pulses held idle
//   clear_count  synchronous clear of both counters and the overflow flag
//   level_out    filtered, qualified level
//   set_pulse    high PULSE_WIDTH cycles after a qualified rise
//   reset_pulse  high PULSE_WIDTH cycles after a qualified fall
//   busy         high while qualifying a level change or emitting a pulse
//   rise_count   number of qualified rising edges (saturating)
//   fall_count   number of qualified falling edges (saturating)
//   overflow     sticky: an increment was attempted on a saturated counter
// -----------------------------------------------------------------------------
module level_to_set_reset #(
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned PULSE_WIDTH   = 1,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter logic        INITIAL_STATE = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 level_in,
  input  logic                 enable,
  input  logic                 clear_count,
  output logic                 level_out,
  output logic                 set_pulse,
  output logic                 reset_pulse,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] rise_count,
  output logic [CNT_WIDTH-1:0] fall_count,
  output logic                 overflow
);

  localparam int unsigned FW  = $clog2(FILTER_CYCLES + 1);
  localparam int unsigned PWW = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;

  localparam logic [FW-1:0]  FILT_MAX = FW'(FILTER_CYCLES);
  localparam logic [FW-1:0]  FILT_SAT = FW'(FILTER_CYCLES - 1);
  localparam logic [PWW-1:0] PW_LOAD  = PWW'(PULSE_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_PULSE   = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [FW-1:0]        r_filtCnt;
  logic [PWW-1:0]       r_pulseLeft;
  logic                 r_levelOut;
  logic                 r_setPulse;
  logic                 r_resetPulse;
  logic [CNT_WIDTH-1:0] r_riseCount;
  logic [CNT_WIDTH-1:0] r_fallCount;
  logic                 r_overflow;

  logic w_diff;
  logic w_qualify;

  // The synchronized level differs from the currently published level.
  assign w_diff = r_sync2 ^ r_levelOut;

  // A qualification fires on the edge where the filter has already seen
  // FILTER_CYCLES differing samples and the difference is still present.
  assign w_qualify = enable && (r_state == ST_QUALIFY) && w_diff &&
                     (r_filtCnt == FILT_MAX);

  // Synchronizer plus the qualify/pulse state machine. During a pulse the
  // filter keeps counting but stops one short of qualifying, so a change that
  // arrives mid-pulse qualifies on the cycle after the pulse has dropped and
  // the two pulses are always separated by at least one low cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1      <= INITIAL_STATE;
      r_sync2      <= INITIAL_STATE;
      r_state      <= ST_IDLE;
      r_filtCnt    <= '0;
      r_pulseLeft  <= '0;
      r_levelOut   <= INITIAL_STATE;
      r_setPulse   <= 1'b0;
      r_resetPulse <= 1'b0;
    end else begin
      r_sync1 <= level_in;
      r_sync2 <= r_sync1;
      if (!enable) begin
        r_state      <= ST_IDLE;
        r_filtCnt    <= '0;
        r_pulseLeft  <= '0;
        r_setPulse   <= 1'b0;
        r_resetPulse <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_diff) begin
              r_state   <= ST_QUALIFY;
              r_filtCnt <= FW'(1);
            end
          end
          ST_QUALIFY: begin
            if (!w_diff) begin
              r_state   <= ST_IDLE;
              r_filtCnt <= '0;
            end else if (r_filtCnt == FILT_MAX) begin
              r_levelOut   <= r_sync2;
              r_setPulse   <= r_sync2;
              r_resetPulse <= ~r_sync2;
              r_pulseLeft  <= PW_LOAD;
              r_filtCnt    <= '0;
              r_state      <= ST_PULSE;
            end else begin
              r_filtCnt <= r_filtCnt + 1'b1;
            end
          end
          ST_PULSE: begin
            if (r_pulseLeft == '0) begin
              r_setPulse   <= 1'b0;
              r_resetPulse <= 1'b0;
              if (w_diff) begin
                r_state   <= ST_QUALIFY;
                r_filtCnt <= r_filtCnt + 1'b1;
              end else begin
                r_state   <= ST_IDLE;
                r_filtCnt <= '0;
              end
            end else begin
              r_pulseLeft <= r_pulseLeft - 1'b1;
              if (!w_diff) begin
                r_filtCnt <= '0;
              end else if (r_filtCnt < FILT_SAT) begin
                r_filtCnt <= r_filtCnt + 1'b1;
              end
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_filtCnt <= '0;
          end
        endcase
      end
    end
  end

  // Edge counters saturate at all-ones; an increment attempted there sets the
  // sticky overflow. A clear on the same cycle as an edge wins, and that edge
  // is not counted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_riseCount <= '0;
      r_fallCount <= '0;
      r_overflow  <= 1'b0;
    end else if (clear_count) begin
      r_riseCount <= '0;
      r_fallCount <= '0;
      r_overflow  <= 1'b0;
    end else if (w_qualify) begin
      if (r_sync2) begin
        if (&r_riseCount) begin
          r_overflow <= 1'b1;
        end else begin
          r_riseCount <= r_riseCount + 1'b1;
        end
      end else begin
        if (&r_fallCount) begin
          r_overflow <= 1'b1;
        end else begin
          r_fallCount <= r_fallCount + 1'b1;
        end
      end
    end
  end

  assign level_out   = r_levelOut;
  assign set_pulse   = r_setPulse;
  assign reset_pulse = r_resetPulse;
  assign busy        = (r_state != ST_IDLE);
  assign rise_count  = r_riseCount;
  assign fall_count  = r_fallCount;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_level_to_set_reset.sv
// -----------------------------------------------------------------------------
// tb_level_to_set_reset
//
// Two instances share one stimulus stream: A uses the default parameters,
// B uses a one-cycle filter, three-cycle pulses, 2-bit counters and a high
// reset level. A run-length model of each instance is checked against the
// DUT outputs on every falling clock edge, and directed scenarios add
// hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_level_to_set_reset;

  localparam int   A_F    = 4;
  localparam int   A_PW   = 1;
  localparam int   A_CW   = 16;
  localparam logic A_INIT = 1'b0;
  localparam int   B_F    = 1;
  localparam int   B_PW   = 3;
  localparam int   B_CW   = 2;
  localparam logic B_INIT = 1'b1;

  logic clock;
  logic reset_n;
  logic level_in;
  logic enable;
  logic clear_count;

  logic            aLevel, aSet, aRst, aBusy, aOvf;
  logic [A_CW-1:0] aRise, aFall;
  logic            bLevel, bSet, bRst, bBusy, bOvf;
  logic [B_CW-1:0] bRise, bFall;

  int testsRun  = 0;
  int failCount = 0;

  // Model state per instance: two-stage sync queue, run length of consecutive
  // differing samples, remaining pulse cycles and its polarity, counters.
  int mSync0[2], mSync1[2], mLevel[2], mRun[2];
  int mPulseRem[2], mPulseRise[2], mRise[2], mFall[2], mOvf[2];

  level_to_set_reset #(
    .FILTER_CYCLES(A_F), .PULSE_WIDTH(A_PW), .CNT_WIDTH(A_CW), .INITIAL_STATE(A_INIT)
  ) uA (
    .clock(clock), .reset_n(reset_n), .level_in(level_in), .enable(enable),
    .clear_count(clear_count), .level_out(aLevel), .set_pulse(aSet),
    .reset_pulse(aRst), .busy(aBusy), .rise_count(aRise), .fall_count(aFall),
    .overflow(aOvf)
  );

  level_to_set_reset #(
    .FILTER_CYCLES(B_F), .PULSE_WIDTH(B_PW), .CNT_WIDTH(B_CW), .INITIAL_STATE(B_INIT)
  ) uB (
    .clock(clock), .reset_n(reset_n), .level_in(level_in), .enable(enable),
    .clear_count(clear_count), .level_out(bLevel), .set_pulse(bSet),
    .reset_pulse(bRst), .busy(bBusy), .rise_count(bRise), .fall_count(bFall),
    .overflow(bOvf)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic int pF(input int d);
    return (d == 0) ? A_F : B_F;
  endfunction

  function automatic int pPW(input int d);
    return (d == 0) ? A_PW : B_PW;
  endfunction

  function automatic int pMax(input int d);
    return (d == 0) ? ((1 << A_CW) - 1) : ((1 << B_CW) - 1);
  endfunction

  function automatic int pInit(input int d);
    return (d == 0) ? int'(A_INIT) : int'(B_INIT);
  endfunction

  function automatic void modelReset();
    for (int d = 0; d < 2; d++) begin
      mSync0[d]     = pInit(d);
      mSync1[d]     = pInit(d);
      mLevel[d]     = pInit(d);
      mRun[d]       = 0;
      mPulseRem[d]  = 0;
      mPulseRise[d] = 0;
      mRise[d]      = 0;
      mFall[d]      = 0;
      mOvf[d]       = 0;
    end
  endfunction

  // A change qualifies once it has been seen on FILTER_CYCLES+1 consecutive
  // synced samples, but never while a pulse is still high or is dropping on
  // this same edge.
  function automatic void modelStep();
    for (int d = 0; d < 2; d++) begin
      int lvlS;
      int eligible;
      int diff;
      lvlS      = mSync1[d];
      mSync1[d] = mSync0[d];
      mSync0[d] = int'(level_in);
      if (!enable) begin
        mRun[d]      = 0;
        mPulseRem[d] = 0;
      end else begin
        eligible = (mPulseRem[d] == 0) ? 1 : 0;
        if (mPulseRem[d] > 0) mPulseRem[d] = mPulseRem[d] - 1;
        diff    = (lvlS != mLevel[d]) ? 1 : 0;
        mRun[d] = diff ? mRun[d] + 1 : 0;
        if (eligible && diff && mRun[d] >= pF(d) + 1) begin
          mLevel[d]     = lvlS;
          mRun[d]       = 0;
          mPulseRem[d]  = pPW(d);
          mPulseRise[d] = lvlS;
          if (lvlS != 0) begin
            if (mRise[d] == pMax(d)) mOvf[d] = 1;
            else mRise[d] = mRise[d] + 1;
          end else begin
            if (mFall[d] == pMax(d)) mOvf[d] = 1;
            else mFall[d] = mFall[d] + 1;
          end
        end
      end
      if (clear_count) begin
        mRise[d] = 0;
        mFall[d] = 0;
        mOvf[d]  = 0;
      end
    end
  endfunction

  initial begin
    modelReset();
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) modelReset();
      else modelStep();
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkDut(input int d, input string pre, input logic [31:0] lv,
                          input logic [31:0] st, input logic [31:0] rs,
                          input logic [31:0] bz, input logic [31:0] ri,
                          input logic [31:0] fa, input logic [31:0] ov);
    checkOutput($sformatf("%s_level", pre), lv, 32'(mLevel[d]));
    checkOutput($sformatf("%s_set", pre), st, 32'(mPulseRem[d] > 0 && mPulseRise[d] != 0));
    checkOutput($sformatf("%s_reset", pre), rs, 32'(mPulseRem[d] > 0 && mPulseRise[d] == 0));
    checkOutput($sformatf("%s_busy", pre), bz, 32'(mPulseRem[d] > 0 || mRun[d] > 0));
    checkOutput($sformatf("%s_rise", pre), ri, 32'(mRise[d]));
    checkOutput($sformatf("%s_fall", pre), fa, 32'(mFall[d]));
    checkOutput($sformatf("%s_ovf", pre), ov, 32'(mOvf[d]));
    checkOutput($sformatf("%s_excl", pre), 32'(st[0] & rs[0]), 0);
  endtask

  initial begin
    forever begin
      @(negedge clock);
      checkDut(0, "A", 32'(aLevel), 32'(aSet), 32'(aRst), 32'(aBusy),
               32'(aRise), 32'(aFall), 32'(aOvf));
      checkDut(1, "B", 32'(bLevel), 32'(bSet), 32'(bRst), 32'(bBusy),
               32'(bRise), 32'(bFall), 32'(bOvf));
    end
  end

  task automatic applyStimulus(input logic lvl, input logic en, input logic clr);
    level_in    = lvl;
    enable      = en;
    clear_count = clr;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic seen;
    logic rl;
    logic ren;
    int   hold;
    int   enHold;

    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    #12;
    checkOutput("rst_levelA", 32'(aLevel), 0);
    checkOutput("rst_levelB", 32'(bLevel), 1);
    checkOutput("rst_setA", 32'(aSet), 0);
    checkOutput("rst_busyB", 32'(bBusy), 0);
    checkOutput("rst_riseB", 32'(bRise), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Glitch: high for three sampled cycles on A is filtered out.
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitEdges(3);
    applyStimulus(1'b0, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      waitEdges(1);
      seen = seen | aSet | aRst;
    end
    checkOutput("t2_pulseA", 32'(seen), 0);
    checkOutput("t2_levelA", 32'(aLevel), 0);
    checkOutput("t2_riseA", 32'(aRise), 0);

    // Clean rise on A: set pulse appears after edge 6, for one cycle.
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitEdges(6);
    checkOutput("t1_setA_e5", 32'(aSet), 0);
    checkOutput("t1_levelA_e5", 32'(aLevel), 0);
    waitEdges(1);
    checkOutput("t1_setA_e6", 32'(aSet), 1);
    checkOutput("t1_levelA_e6", 32'(aLevel), 1);
    checkOutput("t1_riseA_e6", 32'(aRise), 1);
    checkOutput("t1_rstA_e6", 32'(aRst), 0);
    checkOutput("t1_busyA_e6", 32'(aBusy), 1);
    checkOutput("t1_model_riseA", 32'(mRise[0]), 1);
    waitEdges(1);
    checkOutput("t1_setA_e7", 32'(aSet), 0);
    waitEdges(10);

    // B: fall, then rise one cycle after qualification; three-cycle pulses.
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitEdges(3);
    checkOutput("t3_rstB_e2", 32'(bRst), 0);
    waitEdges(1);
    checkOutput("t3_rstB_e3", 32'(bRst), 1);
    checkOutput("t3_levelB_e3", 32'(bLevel), 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitEdges(2);
    checkOutput("t3_rstB_e5", 32'(bRst), 1);
    checkOutput("t3_setB_e5", 32'(bSet), 0);
    waitEdges(1);
    checkOutput("t3_rstB_e6", 32'(bRst), 0);
    checkOutput("t3_setB_e6", 32'(bSet), 0);
    checkOutput("t3_busyB_e6", 32'(bBusy), 1);
    waitEdges(1);
    checkOutput("t3_setB_e7", 32'(bSet), 1);
    checkOutput("t3_levelB_e7", 32'(bLevel), 1);
    checkOutput("t3_model_levelB", 32'(mLevel[1]), 1);
    waitEdges(2);
    checkOutput("t3_setB_e9", 32'(bSet), 1);
    waitEdges(1);
    checkOutput("t3_setB_e10", 32'(bSet), 0);
    waitEdges(8);

    // Counter saturation on B's 2-bit counters.
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitEdges(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitEdges(8);
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitEdges(8);
    end
    checkOutput("t4_riseA", 32'(aRise), 4);
    checkOutput("t4_fallA", 32'(aFall), 4);
    checkOutput("t4_riseB", 32'(bRise), 3);
    checkOutput("t4_fallB", 32'(bFall), 3);
    checkOutput("t4_ovfB", 32'(bOvf), 1);
    checkOutput("t4_model_ovfB", 32'(mOvf[1]), 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitEdges(8);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitEdges(3);
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitEdges(1);
    checkOutput("t4_setB_clr", 32'(bSet), 1);
    checkOutput("t4_riseB_clr", 32'(bRise), 0);
    checkOutput("t4_fallB_clr", 32'(bFall), 0);
    checkOutput("t4_ovfB_clr", 32'(bOvf), 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitEdges(5);
    checkOutput("t4_riseA_after", 32'(aRise), 1);
    checkOutput("t4_ovfA_after", 32'(aOvf), 0);
    waitEdges(6);

    // Disable in the middle of B's pulse, then re-enable with a new level.
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitEdges(4);
    checkOutput("t5_rstB_on", 32'(bRst), 1);
    checkOutput("t5_busyB_on", 32'(bBusy), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitEdges(1);
    checkOutput("t5_rstB_off", 32'(bRst), 0);
    checkOutput("t5_busyB_off", 32'(bBusy), 0);
    checkOutput("t5_levelB_off", 32'(bLevel), 0);
    checkOutput("t5_fallB_off", 32'(bFall), 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitEdges(6);
    checkOutput("t5_levelB_hold", 32'(bLevel), 0);
    checkOutput("t5_setB_hold", 32'(bSet), 0);
    checkOutput("t5_busyB_hold", 32'(bBusy), 0);
    checkOutput("t5_riseB_hold", 32'(bRise), 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitEdges(1);
    checkOutput("t5_setB_q", 32'(bSet), 0);
    checkOutput("t5_busyB_q", 32'(bBusy), 1);
    waitEdges(1);
    checkOutput("t5_setB_p", 32'(bSet), 1);
    checkOutput("t5_levelB_p", 32'(bLevel), 1);
    checkOutput("t5_riseB_p", 32'(bRise), 1);
    waitEdges(6);

    // Asynchronous reset in the middle of qualification.
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitEdges(3);
    checkOutput("t6_busyA_pre", 32'(aBusy), 1);
    checkOutput("t6_busyB_pre", 32'(bBusy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t6_levelA", 32'(aLevel), 0);
    checkOutput("t6_levelB", 32'(bLevel), 1);
    checkOutput("t6_pulsesA", 32'(aSet | aRst), 0);
    checkOutput("t6_pulsesB", 32'(bSet | bRst), 0);
    checkOutput("t6_busyA", 32'(aBusy), 0);
    checkOutput("t6_busyB", 32'(bBusy), 0);
    checkOutput("t6_countsA", 32'(aRise) + 32'(aFall), 0);
    checkOutput("t6_countsB", 32'(bRise) + 32'(bFall), 0);
    checkOutput("t6_ovf", 32'(aOvf | bOvf), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Randomized level, enable and clear traffic.
    rl     = 1'b0;
    ren    = 1'b1;
    hold   = 0;
    enHold = 20;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        rl   = ~rl;
        hold = $urandom_range(1, 12);
      end
      hold--;
      if (enHold == 0) begin
        ren    = ($urandom_range(0, 9) != 0);
        enHold = ren ? $urandom_range(10, 60) : $urandom_range(1, 8);
      end
      enHold--;
      applyStimulus(rl, ren, ren && ($urandom_range(0, 63) == 0));
      waitEdges(1);
    end
    applyStimulus(rl, 1'b1, 1'b0);
    waitEdges(4);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
